frame_cnt_ctrl: RTL and testbench

Sequencing controller for the 15-bit two-field frame counter (12-bit LSB field, 3-bit MSB field) used across the counter datapath. It owns the counter registers, decides when the next-value logic is applied (start/stop/tick), supports preload and clear, and latches the illegal-LSB error until acknowledged. It sits between the timing/trigger logic that produces count ticks and the consumers of the counter value and its status flags.

---
 rtl/frame_cnt_ctrl_pkg.sv | 12 +
 rtl/frame_cnt_next.sv | 30 +++
 rtl/frame_cnt_ctrl.sv | 110 +++++++++++
 tb/tb_frame_cnt_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/frame_cnt_ctrl_pkg.sv
// Shared constants and state encoding for the two-field frame counter.
package frame_cnt_ctrl_pkg;
  localparam logic [11:0] LSB_CNT_MAX = 12'd3563;
  localparam logic        ZERO        = 1'b0;
  localparam logic        ONE         = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_e;
endpackage

// File: rtl/frame_cnt_next.sv
// Combinational next-value logic for the 12-bit LSB / 3-bit MSB frame counter.
module frame_cnt_next #(
  parameter logic [11:0] LSB_CNT_MAX = frame_cnt_ctrl_pkg::LSB_CNT_MAX
) (
  input  logic [11:0] lsb_cnt,
  input  logic [2:0]  msb_cnt,
  output logic [11:0] lsb_nxt,
  output logic [2:0]  msb_nxt,
  output logic        wrap_nxt,
  output logic        err_nxt
);
  import frame_cnt_ctrl_pkg::*;

  always_comb begin
    lsb_nxt  = lsb_cnt;
    msb_nxt  = msb_cnt;
    wrap_nxt = ZERO;
    err_nxt  = ZERO;
    // Out-of-range LSB (only reachable via preload) is flagged, never advanced.
    if (lsb_cnt > LSB_CNT_MAX) begin
      err_nxt = ONE;
    end else if (lsb_cnt == LSB_CNT_MAX) begin
      lsb_nxt  = '0;
      msb_nxt  = msb_cnt + 3'd1;
      wrap_nxt = (msb_cnt == 3'd7);
    end else begin
      lsb_nxt = lsb_cnt + 12'd1;
    end
  end
endmodule

// File: rtl/frame_cnt_ctrl.sv
// Frame counter sequencer: start/stop/tick control, preload, clear and latched range error.
module frame_cnt_ctrl #(
  parameter logic [11:0] LSB_CNT_MAX = frame_cnt_ctrl_pkg::LSB_CNT_MAX
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [11:0] lsb_load_i,
  input  logic [2:0]  msb_load_i,
  input  logic        err_ack_i,
  output logic [11:0] lsb_cnt_o,
  output logic [2:0]  msb_cnt_o,
  output logic        busy_o,
  output logic        wrap_o,
  output logic        err_o,
  output logic [1:0]  state_o
);
  import frame_cnt_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic [11:0] lsb_q, lsb_d, lsb_nxt;
  logic [2:0]  msb_q, msb_d, msb_nxt;
  logic        err_q, err_d, wrap_q, wrap_d;
  logic        wrap_nxt, err_nxt;

  frame_cnt_next #(.LSB_CNT_MAX(LSB_CNT_MAX)) u_next (
    .lsb_cnt (lsb_q),
    .msb_cnt (msb_q),
    .lsb_nxt (lsb_nxt),
    .msb_nxt (msb_nxt),
    .wrap_nxt(wrap_nxt),
    .err_nxt (err_nxt)
  );

  always_comb begin
    state_d = state_q;
    lsb_d   = lsb_q;
    msb_d   = msb_q;
    err_d   = err_q;
    wrap_d  = ZERO;
    if (clear_i) begin
      state_d = ST_IDLE;
      lsb_d   = '0;
      msb_d   = '0;
      err_d   = ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            lsb_d = lsb_load_i;
            msb_d = msb_load_i;
          end else if (start_i && !stop_i) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_d = ST_IDLE;
          end else if (tick_i) begin
            if (err_nxt) begin
              err_d   = ONE;
              state_d = ST_ERROR;
            end else begin
              lsb_d  = lsb_nxt;
              msb_d  = msb_nxt;
              wrap_d = wrap_nxt;
            end
          end
        end
        ST_ERROR: begin
          if (err_ack_i) begin
            state_d = ST_IDLE;
            lsb_d   = '0;
            msb_d   = '0;
            err_d   = ZERO;
          end
        end
        // Unused encoding: recover to IDLE, counters held.
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      lsb_q   <= '0;
      msb_q   <= '0;
      err_q   <= ZERO;
      wrap_q  <= ZERO;
    end else begin
      state_q <= state_d;
      lsb_q   <= lsb_d;
      msb_q   <= msb_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign lsb_cnt_o = lsb_q;
  assign msb_cnt_o = msb_q;
  assign busy_o    = (state_q == ST_RUN);
  assign wrap_o    = wrap_q;
  assign err_o     = err_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_frame_cnt_ctrl.sv
// Directed bench for frame_cnt_ctrl: behavioural counter model checked every cycle, plus pinned literals.
module tb_frame_cnt_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, tick = 1'b0, load = 1'b0, err_ack = 1'b0;
  logic [11:0] lsb_load = '0;
  logic [2:0]  msb_load = '0;
  logic [11:0] lsb_cnt;
  logic [2:0]  msb_cnt;
  logic        busy, wrap, err;
  logic [1:0]  state;

  int nvec = 0, nerr = 0;
  int m_lsb = 0, m_msb = 0, m_state = 0, m_err = 0, m_wrap = 0;
  bit armed = 1'b0;
  localparam int LMAX = 3563;
  localparam int SPAN = LMAX + 1;

  always #5 clk = ~clk;

  frame_cnt_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .tick_i(tick), .load_i(load), .lsb_load_i(lsb_load), .msb_load_i(msb_load),
    .err_ack_i(err_ack), .lsb_cnt_o(lsb_cnt), .msb_cnt_o(msb_cnt), .busy_o(busy),
    .wrap_o(wrap), .err_o(err), .state_o(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the counter as a single value in [0, 8*SPAN), advanced by +1 modulo that range.
  always @(posedge clk) begin
    m_wrap = 0;
    if (rst) begin
      m_lsb = 0; m_msb = 0; m_state = 0; m_err = 0;
    end else if (clear) begin
      m_lsb = 0; m_msb = 0; m_state = 0; m_err = 0;
    end else if (m_state == 0) begin
      if (load) begin
        m_lsb = int'(lsb_load); m_msb = int'(msb_load);
      end else if (start && !stop) m_state = 1;
    end else if (m_state == 1) begin
      if (stop) m_state = 0;
      else if (tick) begin
        if (m_lsb > LMAX) begin
          m_err = 1; m_state = 2;
        end else begin
          int v;
          v = m_msb * SPAN + m_lsb + 1;
          if (v == 8 * SPAN) begin
            v = 0; m_wrap = 1;
          end
          m_lsb = v % SPAN; m_msb = v / SPAN;
        end
      end
    end else if (err_ack) begin
      m_lsb = 0; m_msb = 0; m_state = 0; m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("lsb_cnt", int'(lsb_cnt), m_lsb);
      chk("msb_cnt", int'(msb_cnt), m_msb);
      chk("busy",    int'(busy),    (m_state == 1) ? 1 : 0);
      chk("wrap",    int'(wrap),    m_wrap);
      chk("err",     int'(err),     m_err);
      chk("state",   int'(state),   m_state);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int wrap_hits;

  initial begin
    cyc(2);
    armed = 1'b1;
    chk("reset_lsb", int'(lsb_cnt), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_flags", int'({busy, wrap, err}), 0);
    rst = 1'b0;

    // Full LSB span: 3564 ticks from 0/0 lands on 0/1, no wrap pulse.
    start = 1'b1; tick = 1'b1; cyc(1);
    start = 1'b0;
    wrap_hits = 0;
    for (int i = 0; i < SPAN; i++) begin
      cyc(1);
      if (wrap) wrap_hits++;
    end
    tick = 1'b0;
    chk("span_lsb", int'(lsb_cnt), 0);
    chk("span_msb", int'(msb_cnt), 1);
    chk("span_no_wrap", wrap_hits, 0);

    // Full rollover from 3563/7.
    stop = 1'b1; cyc(1); stop = 1'b0;
    load = 1'b1; lsb_load = 12'd3563; msb_load = 3'd7; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("roll_cnt", int'({msb_cnt, lsb_cnt}), 0);
    chk("roll_wrap", int'(wrap), 1);
    cyc(1);
    chk("roll_wrap_once", int'(wrap), 0);

    // Illegal preload -> ERROR, sticky until acknowledged.
    stop = 1'b1; cyc(1); stop = 1'b0;
    load = 1'b1; lsb_load = 12'd4000; msb_load = 3'd2; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    tick = 1'b1; cyc(1);
    chk("err_set", int'(err), 1);
    chk("err_state", int'(state), 2);
    chk("err_hold", int'(lsb_cnt), 4000);
    start = 1'b1; load = 1'b1; lsb_load = 12'd7; stop = 1'b1; cyc(3);
    chk("err_ignore", int'(lsb_cnt), 4000);
    chk("err_ignore_st", int'(state), 2);
    start = 1'b0; load = 1'b0; stop = 1'b0; tick = 1'b0;
    err_ack = 1'b1; cyc(1); err_ack = 1'b0;
    chk("ack_cnt", int'({msb_cnt, lsb_cnt}), 0);
    chk("ack_flags", int'({err, state}), 0);

    // Stop beats tick; start+stop in IDLE stays IDLE.
    load = 1'b1; lsb_load = 12'd5; msb_load = 3'd0; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    tick = 1'b1; cyc(5);
    stop = 1'b1; cyc(1);
    chk("stop_lsb", int'(lsb_cnt), 10);
    chk("stop_state", int'(state), 0);
    start = 1'b1; cyc(1);
    chk("startstop_idle", int'(state), 0);
    start = 1'b0; stop = 1'b0; tick = 1'b0;

    // Clear beats tick in RUN; load ignored in RUN.
    start = 1'b1; cyc(1); start = 1'b0;
    tick = 1'b1; cyc(90);
    chk("pre_clear_lsb", int'(lsb_cnt), 100);
    clear = 1'b1; cyc(1); clear = 1'b0; tick = 1'b0;
    chk("clear_cnt", int'({msb_cnt, lsb_cnt}), 0);
    chk("clear_state", int'(state), 0);
    start = 1'b1; cyc(1); start = 1'b0;
    load = 1'b1; lsb_load = 12'd77; msb_load = 3'd5; cyc(1); load = 1'b0;
    chk("run_load_ign", int'(lsb_cnt), 0);
    chk("run_load_st", int'(state), 1);

    // Reset mid-count at 500/3.
    stop = 1'b1; cyc(1); stop = 1'b0;
    load = 1'b1; lsb_load = 12'd495; msb_load = 3'd3; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    tick = 1'b1; cyc(5);
    chk("pre_rst", int'({msb_cnt, lsb_cnt}), (3 << 12) | 500);
    rst = 1'b1; cyc(1);
    chk("rst_cnt", int'({msb_cnt, lsb_cnt}), 0);
    chk("rst_flags", int'({busy, wrap, err, state}), 0);
    rst = 1'b0; tick = 1'b0; cyc(2);

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
